// File: rtl/sw_input_conditioner_if.sv
// Switch conditioner bus: raw switches in, conditioned
// switches and ready strobe out.
interface sw_input_conditioner_if #(
  parameter int n = 8
) ();
  logic [n:0] sw_raw;
  logic [n:0] SW;
  logic       press_pulse;

  modport master (
    output sw_raw,
    input  SW,
    input  press_pulse
  );

  modport slave (
    input  sw_raw,
    output SW,
    output press_pulse
  );
endinterface

// File: rtl/sw_input_conditioner.sv
// Synchronises and debounces board switches for the picoMIPS
// SW port; switch n becomes a debounced ready flag that freezes data.
module sw_input_conditioner #(
  parameter  int n         = 8,
  parameter  int DB_CYCLES = 16,
  localparam int CW        = $clog2(DB_CYCLES)
) (
  input logic                   clk,
  input logic                   reset,
  sw_input_conditioner_if.slave bus
);

  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [n:0]    s1_q, s2_q;
  logic [n-1:0]  cand_q, cand_d;
  logic [n-1:0]  deb_q, deb_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] fcnt_q;
  logic [n:0]    sw_q;
  logic          pulse_q;
  state_t        state_q;

  assign bus.SW          = sw_q;
  assign bus.press_pulse = pulse_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.sw_raw;
      s2_q <= s1_q;
    end
  end

  // One shared counter: any data bit moving restarts the window.
  always_comb begin
    cand_d = cand_q;
    dcnt_d = dcnt_q;
    deb_d  = deb_q;
    if (s2_q[n-1:0] != cand_q) begin
      cand_d = s2_q[n-1:0];
      dcnt_d = '0;
    end else if (dcnt_q < CMAX) begin
      dcnt_d = dcnt_q + 1'b1;
    end else begin
      deb_d = cand_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q <= '0;
      dcnt_q <= '0;
      deb_q  <= '0;
    end else begin
      cand_q <= cand_d;
      dcnt_q <= dcnt_d;
      deb_q  <= deb_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      sw_q    <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sw_q[n] <= 1'b0;
          if (s2_q[n]) begin
            state_q <= PRESS_WAIT;
            fcnt_q  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[n]) begin
            state_q <= IDLE;
          end else if (fcnt_q == CMAX) begin
            state_q <= HELD;
            sw_q[n] <= 1'b1;
            pulse_q <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
        HELD: begin
          if (!s2_q[n]) begin
            state_q <= RELEASE_WAIT;
            fcnt_q  <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s2_q[n]) begin
            state_q <= HELD;
          end else if (fcnt_q == CMAX) begin
            state_q <= IDLE;
            sw_q[n] <= 1'b0;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Data tracks deb until the press edge, then holds.
      if (state_q == IDLE || state_q == PRESS_WAIT) begin
        sw_q[n-1:0] <= deb_q;
      end
    end
  end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner: expected SW values and
// press counts are queued with their edge and checked at the negedge.
module tb_sw_input_conditioner;

  typedef struct {
    string      tag;
    int         cyc;
    bit         kind;
    logic [8:0] mask;
    logic [8:0] exp;
  } item_t;

  logic clk;
  logic reset;
  int   cyc;
  int   base;
  int   npulse;
  int   ncmp;
  int   nfail;
  bit   done;
  bit   done_chk;
  item_t q[$];

  sw_input_conditioner_if #(.n(8)) bus ();

  sw_input_conditioner #(
    .n(8),
    .DB_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    npulse   = 0;
    ncmp     = 0;
    nfail    = 0;
    done_chk = 1'b0;
  end

  always @(negedge clk) begin
    item_t      it;
    logic [8:0] obs;
    if (bus.press_pulse === 1'b1) npulse++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it  = q.pop_front();
      obs = it.kind ? 9'(npulse) : bus.SW;
      ncmp++;
      assert ((it.cyc == cyc) && ((obs & it.mask) === (it.exp & it.mask)))
      else begin
        nfail++;
        $error("FAIL %s cyc=%0d observed=%h expected=%h mask=%h",
               it.tag, cyc, obs, it.exp, it.mask);
      end
    end
    if (done && !done_chk) begin
      done_chk = 1'b1;
      ncmp++;
      assert (q.size() == 0)
      else begin
        nfail++;
        $error("FAIL unchecked_items observed=%0d expected=0", q.size());
      end
    end
  end

  task automatic expect_sw(string tag, int k,
                           logic [8:0] mask, logic [8:0] exp);
    q.push_back('{tag, base + k, 1'b0, mask, exp});
  endtask

  task automatic expect_np(string tag, int k, int n);
    q.push_back('{tag, base + k, 1'b1, 9'h1FF, 9'(n)});
  endtask

  task automatic wait_n(int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    done        = 1'b0;
    reset       = 1'b0;
    bus.sw_raw  = 9'h1FF;
    base        = 0;
    expect_sw("rst_hold", 3, 9'h1FF, 9'h000);
    expect_np("rst_np", 3, 0);
    wait_n(4);
    bus.sw_raw = 9'h0FF;
    wait_n(1);
    reset = 1'b1;
    base  = cyc;
    expect_sw("rst_e19", 19, 9'h1FF, 9'h000);
    expect_sw("rst_e20", 20, 9'h1FF, 9'h0FF);
    wait_n(30);

    bus.sw_raw[7:0] = 8'hA5;
    base = cyc;
    expect_sw("idle_a5", 25, 9'h1FF, 9'h0A5);
    wait_n(30);

    bus.sw_raw[8] = 1'b1;
    base = cyc;
    expect_sw("press_e18", 18, 9'h1FF, 9'h0A5);
    expect_sw("press_e19", 19, 9'h1FF, 9'h1A5);
    expect_np("press_np19", 19, 1);
    expect_np("press_np24", 24, 1);
    wait_n(25);

    bus.sw_raw[8] = 1'b0;
    base = cyc;
    expect_sw("bounce_mid", 12, 9'h1FF, 9'h1A5);
    expect_sw("bounce_end", 30, 9'h1FF, 9'h1A5);
    expect_np("bounce_np", 30, 1);
    wait_n(8);
    bus.sw_raw[8] = 1'b1;
    wait_n(23);

    bus.sw_raw[7:0] = 8'h5A;
    base = cyc;
    expect_sw("freeze", 30, 9'h1FF, 9'h1A5);
    wait_n(31);
    bus.sw_raw[8] = 1'b0;
    base = cyc;
    expect_sw("rel_e18", 18, 9'h1FF, 9'h1A5);
    expect_sw("rel_e19", 19, 9'h1FF, 9'h0A5);
    expect_sw("rel_e20", 20, 9'h1FF, 9'h05A);
    wait_n(25);

    bus.sw_raw[7:0] = 8'h3C;
    base = cyc;
    expect_sw("idle_3c", 25, 9'h1FF, 9'h03C);
    wait_n(30);
    bus.sw_raw[8] = 1'b1;
    base = cyc;
    expect_sw("glitch_15", 15, 9'h100, 9'h000);
    expect_sw("glitch_30", 30, 9'h100, 9'h000);
    expect_sw("glitch_45", 45, 9'h100, 9'h000);
    expect_sw("glitch_end", 70, 9'h1FF, 9'h03C);
    expect_np("glitch_np", 70, 1);
    wait_n(10);
    for (int i = 0; i < 40; i++) begin
      bus.sw_raw[8] = ((i / 3) % 2) == 1;
      wait_n(1);
    end
    bus.sw_raw[8] = 1'b0;
    wait_n(21);

    bus.sw_raw[8] = 1'b1;
    wait_n(10);
    @(posedge clk);
    #2 reset = 1'b0;
    base = cyc;
    expect_sw("rst_pw_async", 0, 9'h1FF, 9'h000);
    wait_n(2);
    reset = 1'b1;
    base  = cyc;
    expect_sw("pw_rel_e18", 18, 9'h100, 9'h000);
    expect_sw("pw_rel_e19", 19, 9'h1FF, 9'h100);
    expect_np("pw_rel_np", 19, 2);
    wait_n(25);

    @(posedge clk);
    #2 reset = 1'b0;
    base = cyc;
    expect_sw("rst_held_async", 0, 9'h1FF, 9'h000);
    wait_n(2);
    reset = 1'b1;
    base  = cyc;
    expect_sw("held_rel_e18", 18, 9'h100, 9'h000);
    expect_sw("held_rel_e19", 19, 9'h1FF, 9'h100);
    expect_np("held_rel_np", 19, 3);
    wait_n(25);

    done = 1'b1;
    wait_n(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
